// File: rtl/cart_loader.sv
// Cartridge load sequencer: arbitrates the cartridge ROM port between the HPS
// download stream, a post-load mirror pass and the A2601 core.
module cart_loader #(
  parameter int ADDR_W   = 15,
  parameter int MIN_BANK = 2048
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [31:0]       ioctl_file_ext,
  input  logic [1:0]        sc_mode,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [7:0]        core_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic              core_reset,
  output logic              ioctl_wait,
  output logic [3:0]        force_bs,
  output logic              sc,
  output logic [16:0]       rom_size
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MIRROR_RD, S_MIRROR_WR} state_t;

  localparam int              PW        = ADDR_W + 1;
  localparam logic [PW-1:0]   ROM_BYTES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [16:0]     COUNT_MAX = '1;

  state_t          r_state, w_next;
  logic            r_dl_d;
  logic [16:0]     r_count;
  logic [PW-1:0]   r_ptr;
  logic [3:0]      r_force_bs;
  logic            r_sc;
  logic [16:0]     r_rom_size;

  logic            w_dl_rise, w_dl_fall;
  logic            w_in_rom;
  logic [25:0]     w_addr_p1;
  logic [16:0]     w_addr_sat;
  logic [PW-1:0]   w_target;
  logic [PW-1:0]   w_ptr_p1;
  logic [PW-1:0]   w_src;
  logic            w_no_mirror;
  logic            w_mirror_done;
  logic [23:0]     w_ext;
  logic [3:0]      w_bs;
  logic            w_sc;

  assign w_dl_rise     = ioctl_download & ~r_dl_d;
  assign w_dl_fall     = ~ioctl_download & r_dl_d;
  assign w_in_rom      = ~|ioctl_addr[24:ADDR_W];
  assign w_addr_p1     = {1'b0, ioctl_addr} + 26'd1;
  assign w_addr_sat    = (w_addr_p1 > 26'(COUNT_MAX)) ? COUNT_MAX : w_addr_p1[16:0];
  assign w_ptr_p1      = r_ptr + PW'(1);
  assign w_src         = r_ptr - PW'(r_count);
  assign w_no_mirror   = (r_count == 17'd0) || (32'(r_count) >= 32'(w_target));
  assign w_mirror_done = (w_ptr_p1 == w_target);

  // Mirror target: smallest power of two >= count, clamped to [MIN_BANK, ROM size].
  always_comb begin
    w_target = ROM_BYTES;
    for (int i = ADDR_W; i >= 0; i--) begin
      if (((32'd1 << i) >= 32'(MIN_BANK)) && ((32'd1 << i) >= 32'(r_count)))
        w_target = PW'(32'd1 << i);
    end
  end

  // Three-char extensions sit in [23:0]; four-char ones carry an extra suffix.
  assign w_ext = (ioctl_file_ext[23:16] == 8'h2E) ? ioctl_file_ext[23:0]
                                                  : ioctl_file_ext[31:8];

  always_comb begin
    case (w_ext)
      ".F8":   w_bs = 4'd1;
      ".F6":   w_bs = 4'd2;
      ".FE":   w_bs = 4'd3;
      ".E0":   w_bs = 4'd4;
      ".3F":   w_bs = 4'd5;
      ".F4":   w_bs = 4'd6;
      ".P2":   w_bs = 4'd7;
      ".FA":   w_bs = 4'd8;
      ".CV":   w_bs = 4'd9;
      default: w_bs = 4'd0;
    endcase
  end

  assign w_sc = (sc_mode == 2'd0) ? (ioctl_file_ext[7:0] == "S") : sc_mode[1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    if (w_dl_rise) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:      if (w_dl_fall) w_next = w_no_mirror ? S_IDLE : S_MIRROR_RD;
        S_MIRROR_RD: w_next = S_MIRROR_WR;
        S_MIRROR_WR: w_next = w_mirror_done ? S_IDLE : S_MIRROR_RD;
        default:     w_next = r_state;
      endcase
    end
  end

  always_comb begin
    mem_addr   = core_addr;
    mem_wr     = 1'b0;
    mem_din    = ioctl_dout;
    core_reset = 1'b0;
    ioctl_wait = 1'b0;
    case (r_state)
      S_LOAD: begin
        core_reset = 1'b1;
        mem_addr   = ioctl_addr[ADDR_W-1:0];
        mem_wr     = ioctl_wr & w_in_rom;
      end
      S_MIRROR_RD: begin
        core_reset = 1'b1;
        ioctl_wait = 1'b1;
        mem_addr   = w_src[ADDR_W-1:0];
      end
      S_MIRROR_WR: begin
        core_reset = 1'b1;
        ioctl_wait = 1'b1;
        mem_addr   = r_ptr[ADDR_W-1:0];
        mem_din    = mem_dout;
        // A restart in this cycle aborts the pass before the write lands.
        mem_wr     = ~w_dl_rise;
      end
      default: ;
    endcase
  end

  assign core_data = mem_dout;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_d     <= 1'b0;
      r_count    <= '0;
      r_ptr      <= '0;
      r_force_bs <= '0;
      r_sc       <= 1'b0;
      r_rom_size <= '0;
    end else begin
      r_dl_d <= ioctl_download;
      if (w_dl_rise) begin
        r_count    <= '0;
        r_force_bs <= w_bs;
        r_sc       <= w_sc;
      end else if (r_state == S_LOAD) begin
        if (ioctl_wr && (w_addr_sat > r_count)) r_count <= w_addr_sat;
        if (w_dl_fall) begin
          r_rom_size <= r_count;
          r_ptr      <= PW'(r_count);
        end
      end else if (r_state == S_MIRROR_WR) begin
        r_ptr <= w_ptr_p1;
      end
    end
  end

  assign force_bs = r_force_bs;
  assign sc       = r_sc;
  assign rom_size = r_rom_size;

endmodule
